counter_updown_mc: RTL and testbench
====================================

COUNTER_UPDOWN_MC -- requirements
Module: counter_updown_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 SHALL have parameter CH, default 4, number of independent counter channels (1..16).
REQ-003 SHALL have parameter STEP, default 1, increment/decrement magnitude (1..2^WIDTH-1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port inc  input  CH  per-channel increment request.
REQ-007 SHALL have port dec  input  CH  per-channel decrement request.
REQ-008 SHALL have port load  input  CH  per-channel synchronous load request.
REQ-009 SHALL have port load_val  input  CH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port mode  input  1  0 = wrap, 1 = saturate; global, sampled every cycle.
REQ-011 SHALL have port flag_clr  input  CH  per-channel clear of sticky ovf/unf.
REQ-012 SHALL have port cnt  output  CH*WIDTH  registered count values, packed as load_val.
REQ-013 SHALL have port ovf  output  CH  sticky overflow flag, registered.
REQ-014 SHALL have port unf  output  CH  sticky underflow flag, registered.
REQ-015 SHALL have port zero  output  CH  combinational, high when that channel's cnt == 0.

Function
REQ-016 Channels SHALL be fully independent; no input of channel i affects channel j.
REQ-017 Per channel, priority SHALL be: load > (inc XOR dec) > hold.
REQ-018 load=1: cnt SHALL take load_val on the next edge regardless of inc/dec; ovf/unf not set.
REQ-019 inc=1 and dec=1 together (no load): cnt SHALL hold; no flag set.
REQ-020 Increment: if cnt+STEP <= MAX (2^WIDTH-1), cnt SHALL become cnt+STEP.
REQ-021 Increment past MAX: wrap mode -> (cnt+STEP) mod 2^WIDTH; saturate mode -> MAX; ovf SHALL be set in both modes.
REQ-022 Decrement: if cnt >= STEP, cnt SHALL become cnt-STEP.
REQ-023 Decrement below 0: wrap mode -> (cnt-STEP) mod 2^WIDTH; saturate mode -> 0; unf SHALL be set in both modes.
REQ-024 Saturate mode at MAX with inc (or at 0 with dec) SHALL hold the value and still set ovf (unf).
REQ-025 Arithmetic SHALL use a WIDTH+1-bit intermediate; no truncation before the overflow/underflow compare.
REQ-026 Latency SHALL be one cycle: inputs sampled at edge N appear on cnt/ovf/unf after edge N.
REQ-027 flag_clr SHALL clear ovf and unf on the next edge; an overflow/underflow event in the same cycle SHALL win (flag ends set).
REQ-028 Mode change SHALL take effect on the first edge it is sampled; no pipeline of mode.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force every cnt to 0, ovf to 0, unf to 0; zero consequently reads all ones.
REQ-030 Reset mid-operation SHALL discard any pending load/inc/dec; first update is on the first rising clk edge after rst falls.

Structure
REQ-031 A shared package counter_pkg SHALL hold typedef cnt_mode_t (CNT_WRAP=0, CNT_SAT=1) and the flag-priority constants; mode port is cast to it internally.
REQ-032 One sub-module counter_chan (single channel: count, ovf, unf, zero) SHALL be instantiated CH times via a generate loop; top does only packing/unpacking.
REQ-033 No latches, no multiple drivers; all state in always_ff with the asynchronous rst.

Verification (WIDTH=8, CH=4, STEP=1 unless stated)
REQ-034 Reset then hold: rst pulse, idle 5 cycles -> cnt all 0, zero=4'b1111, ovf=unf=0.
REQ-035 Wrap overflow: load ch0 with 8'hFF, inc ch0, mode=0 -> cnt0=8'h00, ovf[0]=1, other channels unchanged.
REQ-036 Saturate underflow: ch1 at 0, dec ch1 three cycles, mode=1 -> cnt1 stays 0, unf[1]=1 from first cycle; flag_clr[1] -> unf[1]=0 next cycle.
REQ-037 Conflicts: ch2=8'h10, inc=dec=1 -> hold 8'h10; same with load=1, load_val=8'h55 -> cnt2=8'h55, no flags.
REQ-038 Clear vs event: ch3=8'hFF, mode=1, inc and flag_clr together -> ovf[3]=1, cnt3=8'hFF.
REQ-039 STEP=3, WIDTH=4: cnt=14, inc, wrap -> cnt=1, ovf=1; cnt=2, dec, saturate -> cnt=0, unf=1; plus random run against a reference model checking every cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the multi-channel up/down counter.
// Latency n/a (declarations only); no backpressure.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  // When a flag clear and a new overflow/underflow land in the same cycle,
  // the event wins so that no overflow is ever silently lost.
  localparam bit FLAG_EVENT_OVER_CLR = 1'b1;

endpackage

// File: rtl/counter_chan.sv
// One up/down counter channel with sticky overflow/underflow flags.
// Latency 1 cycle (zero is combinational); no backpressure, accepts every cycle.
module counter_chan
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  cnt_mode_t        mode,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             unf,
  output logic             zero
);

  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX    = '1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_ev;
  logic             unf_ev;
  logic             ovf_nxt;
  logic             unf_nxt;

  // One extra bit keeps the carry/borrow visible for the range check.
  assign sum  = {1'b0, cnt} + STEP_W;
  assign diff = {1'b0, cnt} - STEP_W;

  always_comb begin
    cnt_nxt = cnt;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (load) begin
      cnt_nxt = load_val;
    end else if (inc && !dec) begin
      ovf_ev  = sum[WIDTH];
      cnt_nxt = (ovf_ev && mode == CNT_SAT) ? MAX : sum[WIDTH-1:0];
    end else if (dec && !inc) begin
      unf_ev  = diff[WIDTH];
      cnt_nxt = (unf_ev && mode == CNT_SAT) ? '0 : diff[WIDTH-1:0];
    end
  end

  always_comb begin
    ovf_nxt = ovf;
    unf_nxt = unf;
    if (flag_clr) begin
      ovf_nxt = FLAG_EVENT_OVER_CLR ? ovf_ev : 1'b0;
      unf_nxt = FLAG_EVENT_OVER_CLR ? unf_ev : 1'b0;
    end
    if (ovf_ev) ovf_nxt = 1'b1;
    if (unf_ev) unf_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/counter_updown_mc.sv
// CH independent up/down counters with global wrap/saturate mode.
// Latency 1 cycle (zero is combinational); no backpressure, accepts every cycle.
module counter_updown_mc
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int STEP  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       inc,
  input  logic [CH-1:0]       dec,
  input  logic [CH-1:0]       load,
  input  logic [CH*WIDTH-1:0] load_val,
  input  logic                mode,
  input  logic [CH-1:0]       flag_clr,
  output logic [CH*WIDTH-1:0] cnt,
  output logic [CH-1:0]       ovf,
  output logic [CH-1:0]       unf,
  output logic [CH-1:0]       zero
);

  cnt_mode_t mode_e;
  assign mode_e = cnt_mode_t'(mode);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    counter_chan #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .mode     (mode_e),
      .flag_clr (flag_clr[i]),
      .cnt      (cnt[i*WIDTH +: WIDTH]),
      .ovf      (ovf[i]),
      .unf      (unf[i]),
      .zero     (zero[i])
    );
  end

endmodule

// File: tb/tb_counter_updown_mc.sv
// Directed and randomized checks of counter_updown_mc in two configurations.
module tb_counter_updown_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, CH=4, STEP=1
  logic [3:0]  a_inc, a_dec, a_load, a_clr;
  logic [31:0] a_lv;
  logic        a_mode;
  logic [31:0] a_cnt;
  logic [3:0]  a_ovf, a_unf, a_zero;

  // Instance B: WIDTH=4, CH=2, STEP=3
  logic [1:0]  b_inc, b_dec, b_load, b_clr;
  logic [7:0]  b_lv;
  logic        b_mode;
  logic [7:0]  b_cnt;
  logic [1:0]  b_ovf, b_unf, b_zero;

  counter_updown_mc #(.WIDTH(8), .CH(4), .STEP(1)) dut_a (
    .clk(clk), .rst(rst), .inc(a_inc), .dec(a_dec), .load(a_load),
    .load_val(a_lv), .mode(a_mode), .flag_clr(a_clr),
    .cnt(a_cnt), .ovf(a_ovf), .unf(a_unf), .zero(a_zero)
  );

  counter_updown_mc #(.WIDTH(4), .CH(2), .STEP(3)) dut_b (
    .clk(clk), .rst(rst), .inc(b_inc), .dec(b_dec), .load(b_load),
    .load_val(b_lv), .mode(b_mode), .flag_clr(b_clr),
    .cnt(b_cnt), .ovf(b_ovf), .unf(b_unf), .zero(b_zero)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for instance B
  int m_cnt [2];
  logic [1:0] m_ovf, m_unf;
  int v;
  logic ev_o, ev_u;

  initial begin
    a_inc = '0; a_dec = '0; a_load = '0; a_clr = '0; a_lv = '0; a_mode = 1'b0;
    b_inc = '0; b_dec = '0; b_load = '0; b_clr = '0; b_lv = '0; b_mode = 1'b0;

    // Reset then idle
    #3;
    check("async_rst_cnt", a_cnt, 32'h0);
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    check("idle_cnt", a_cnt, 32'h0);
    check("idle_zero", {28'h0, a_zero}, 32'hF);
    check("idle_ovf", {28'h0, a_ovf}, 32'h0);
    check("idle_unf", {28'h0, a_unf}, 32'h0);

    // Load ch0=FF, ch2=10, ch3=FF
    a_load = 4'b1101; a_lv = 32'hFF10_00FF;
    step();
    check("load_cnt", a_cnt, 32'hFF10_00FF);
    check("load_zero", {28'h0, a_zero}, 32'h2);
    check("load_ovf", {28'h0, a_ovf}, 32'h0);

    // Wrap overflow on ch0
    a_load = '0; a_inc = 4'b0001; a_mode = 1'b0;
    step();
    check("wrap_cnt", a_cnt, 32'hFF10_0000);
    check("wrap_ovf", {28'h0, a_ovf}, 32'h1);
    check("wrap_zero", {28'h0, a_zero}, 32'h3);

    // Saturating underflow on ch1, three cycles
    a_inc = '0; a_dec = 4'b0010; a_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("sat_unf_cnt", a_cnt, 32'hFF10_0000);
      check("sat_unf_flag", {28'h0, a_unf}, 32'h2);
    end

    // Clear unf[1]
    a_dec = '0; a_clr = 4'b0010;
    step();
    check("clr_unf", {28'h0, a_unf}, 32'h0);
    check("clr_keep_ovf", {28'h0, a_ovf}, 32'h1);

    // inc and dec together hold ch2
    a_clr = '0; a_inc = 4'b0100; a_dec = 4'b0100;
    step();
    check("incdec_hold", a_cnt, 32'hFF10_0000);
    check("incdec_flags", {24'h0, a_ovf, a_unf}, 32'h10);

    // load beats inc+dec
    a_load = 4'b0100; a_lv = 32'h0055_0000;
    step();
    check("load_prio_cnt", a_cnt, 32'hFF55_0000);
    check("load_prio_flags", {24'h0, a_ovf, a_unf}, 32'h10);

    // ch3 saturate-at-MAX event beats clear; ch0 clear without event
    a_load = '0; a_dec = '0; a_inc = 4'b1000; a_clr = 4'b1001; a_mode = 1'b1;
    step();
    check("evt_vs_clr_ovf", {28'h0, a_ovf}, 32'h8);
    check("evt_vs_clr_cnt", a_cnt, 32'hFF55_0000);

    // Plain increment ch1 and decrement ch2
    a_clr = '0; a_inc = 4'b0010; a_dec = 4'b0100; a_mode = 1'b0;
    step();
    check("plain_incdec", a_cnt, 32'hFF54_0100);

    // Asynchronous reset mid-cycle with pending increments
    a_inc = 4'hF; a_dec = '0;
    rst = 1'b1;
    #2;
    check("midrst_cnt", a_cnt, 32'h0);
    check("midrst_flags", {24'h0, a_ovf, a_unf}, 32'h0);
    check("midrst_zero", {28'h0, a_zero}, 32'hF);
    #2;
    rst = 1'b0;
    step();
    check("post_rst_inc", a_cnt, 32'h0101_0101);
    a_inc = '0;

    // Instance B directed: STEP=3, WIDTH=4
    b_load = 2'b11; b_lv = 8'h2E;
    step();
    check("b_load", {24'h0, b_cnt}, 32'h2E);
    b_load = '0; b_inc = 2'b01; b_mode = 1'b0;
    step();
    check("b_wrap_cnt", {24'h0, b_cnt}, 32'h21);
    check("b_wrap_ovf", {30'h0, b_ovf}, 32'h1);
    b_inc = '0; b_dec = 2'b10; b_mode = 1'b1;
    step();
    check("b_sat_cnt", {24'h0, b_cnt}, 32'h01);
    check("b_sat_unf", {30'h0, b_unf}, 32'h2);
    check("b_zero", {30'h0, b_zero}, 32'h2);

    // Random run against an arithmetic reference model
    m_cnt[0] = 1; m_cnt[1] = 0; m_ovf = 2'b01; m_unf = 2'b10;
    for (int n = 0; n < 300; n++) begin
      b_inc  = 2'($urandom);
      b_dec  = 2'($urandom);
      b_load = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      b_lv   = 8'($urandom);
      b_mode = 1'($urandom);
      b_clr  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      for (int c = 0; c < 2; c++) begin
        v = m_cnt[c];
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (b_load[c]) begin
          v = int'(b_lv[c*4 +: 4]);
        end else if (b_inc[c] && !b_dec[c]) begin
          v = v + 3;
          if (v > 15) begin
            ev_o = 1'b1;
            v = b_mode ? 15 : v - 16;
          end
        end else if (b_dec[c] && !b_inc[c]) begin
          v = v - 3;
          if (v < 0) begin
            ev_u = 1'b1;
            v = b_mode ? 0 : v + 16;
          end
        end
        m_cnt[c] = v;
        m_ovf[c] = ev_o | (m_ovf[c] & ~b_clr[c]);
        m_unf[c] = ev_u | (m_unf[c] & ~b_clr[c]);
      end
      step();
      check("rnd_cnt", {24'h0, b_cnt}, {24'h0, 4'(m_cnt[1]), 4'(m_cnt[0])});
      check("rnd_ovf", {30'h0, b_ovf}, {30'h0, m_ovf});
      check("rnd_unf", {30'h0, b_unf}, {30'h0, m_unf});
      check("rnd_zero", {30'h0, b_zero}, {30'h0, (m_cnt[1] == 0), (m_cnt[0] == 0)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
